// File: rtl/unary_add_pkg.sv
// Shared types and defaults for the unary-adder job scheduler.
// Latency: n/a (declarations only); backpressure: n/a.
package unary_add_pkg;

  localparam int DEF_OP_W       = 4;
  localparam int DEF_STREAM_LEN = 2**DEF_OP_W - 1;
  localparam int DEF_RES_W      = DEF_OP_W + 1;
  localparam int DEF_DOUT_LAT   = 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    DRAIN,
    RESP
  } state_t;

  // Write-out window: both operand streams can come back as ones, plus adder output lag.
  function automatic int drain_len(input int stream_len, input int dout_lat);
    return 2 * stream_len + dout_lat;
  endfunction

endpackage

// File: rtl/unary_rr_arb.sv
// Round-robin pick of the first valid index at or after ptr; combinational.
// Latency: 0 cycles; backpressure: grant is suppressed while adv is low.
module unary_rr_arb #(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [IDX_W-1:0] ptr,
  input  logic             adv,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W:0]   cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NREQ))
        cand = cand - (IDX_W+1)'(NREQ);
      if (!found && valid[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
    grant = '0;
    if (adv && found)
      grant[idx] = 1'b1;
  end

endmodule

// File: rtl/unary_add_sched.sv
// Time-shares one unary adder among NREQ requesters: clear, stream operands, count dout ones.
// Latency: response 2+3*STREAM_LEN+DOUT_LAT cycles after grant; backpressure: holds RESP until rsp_ready.
module unary_add_sched
  import unary_add_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int OP_W       = DEF_OP_W,
  parameter int STREAM_LEN = 2**OP_W - 1,
  parameter int RES_W      = OP_W + 1,
  parameter int DOUT_LAT   = DEF_DOUT_LAT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*OP_W-1:0]     req_a,
  input  logic [NREQ*OP_W-1:0]     req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [RES_W-1:0]         rsp_sum,
  output logic                     rsp_c,
  output logic                     ua_rst_n,
  output logic                     ua_en,
  output logic                     ua_rw,
  output logic                     ua_a,
  output logic                     ua_b,
  input  logic                     ua_dout,
  input  logic                     ua_c
);

  localparam int ID_W      = $clog2(NREQ);
  localparam int DRAIN_LEN = drain_len(STREAM_LEN, DOUT_LAT);
  localparam int PH_W      = $clog2(DRAIN_LEN + 1);

  state_t            state, state_nx;
  logic [PH_W-1:0]   ph, ph_nx;
  logic [ID_W-1:0]   ptr, ptr_nx;
  logic [OP_W-1:0]   opa, opa_nx, opb, opb_nx;
  logic [ID_W-1:0]   id_nx;
  logic [RES_W-1:0]  sum_nx;
  logic              c_nx;
  logic [NREQ-1:0]   rdy_nx;
  logic              arb_adv;
  logic [NREQ-1:0]   gnt_oh;
  logic [ID_W-1:0]   gnt_idx;

  // A grant is only offered when no accept pulse is already outstanding.
  assign arb_adv = (state == IDLE) && !(|req_ready);

  unary_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (ID_W)
  ) u_arb (
    .valid (req_valid),
    .ptr   (ptr),
    .adv   (arb_adv),
    .grant (gnt_oh),
    .idx   (gnt_idx)
  );

  always_comb begin
    state_nx = state;
    ph_nx    = ph;
    ptr_nx   = ptr;
    opa_nx   = opa;
    opb_nx   = opb;
    id_nx    = rsp_id;
    sum_nx   = rsp_sum;
    c_nx     = rsp_c;
    rdy_nx   = '0;
    case (state)
      IDLE: begin
        if (|req_ready) begin
          state_nx = CLEAR;
        end else if (|gnt_oh) begin
          rdy_nx = gnt_oh;
          opa_nx = req_a[gnt_idx*OP_W +: OP_W];
          opb_nx = req_b[gnt_idx*OP_W +: OP_W];
          id_nx  = gnt_idx;
          ptr_nx = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      CLEAR: begin
        state_nx = LOAD;
        ph_nx    = '0;
        sum_nx   = '0;
        c_nx     = 1'b0;
      end
      LOAD: begin
        c_nx = rsp_c | ua_c;
        if (ph == PH_W'(STREAM_LEN - 1)) begin
          state_nx = DRAIN;
          ph_nx    = '0;
        end else begin
          ph_nx = ph + 1'b1;
        end
      end
      DRAIN: begin
        c_nx = rsp_c | ua_c;
        if (ua_dout && (rsp_sum != {RES_W{1'b1}}))
          sum_nx = rsp_sum + 1'b1;
        if (ph == PH_W'(DRAIN_LEN - 1))
          state_nx = RESP;
        else
          ph_nx = ph + 1'b1;
      end
      RESP: begin
        if (rsp_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Adder controls are registered from the next state so they line up with it cycle-for-cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ph        <= '0;
      ptr       <= '0;
      opa       <= '0;
      opb       <= '0;
      req_ready <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_c     <= 1'b0;
      ua_rst_n  <= 1'b0;
      ua_en     <= 1'b0;
      ua_rw     <= 1'b0;
      ua_a      <= 1'b0;
      ua_b      <= 1'b0;
    end else begin
      state     <= state_nx;
      ph        <= ph_nx;
      ptr       <= ptr_nx;
      opa       <= opa_nx;
      opb       <= opb_nx;
      req_ready <= rdy_nx;
      rsp_valid <= (state_nx == RESP);
      rsp_id    <= id_nx;
      rsp_sum   <= sum_nx;
      rsp_c     <= c_nx;
      ua_rst_n  <= (state_nx != CLEAR);
      ua_en     <= (state_nx == LOAD) || (state_nx == DRAIN);
      ua_rw     <= (state_nx == DRAIN);
      ua_a      <= (state_nx == LOAD) && (ph_nx < PH_W'(opa));
      ua_b      <= (state_nx == LOAD) && (ph_nx < PH_W'(opb));
    end
  end

endmodule

// File: tb/tb_unary_add_sched.sv
// Directed bench for unary_add_sched with a behavioural unary adder.
// Table-driven single jobs plus hand sequences for arbitration, stall and mid-job reset.
module tb_unary_add_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a, req_b;
  logic       rsp_valid, rsp_ready;
  logic       rsp_id;
  logic [4:0] rsp_sum;
  logic       rsp_c;
  logic       ua_rst_n, ua_en, ua_rw, ua_a, ua_b;
  logic       ua_dout = 1'b0;
  logic       ua_c = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  unary_add_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_c     (rsp_c),
    .ua_rst_n  (ua_rst_n),
    .ua_en     (ua_en),
    .ua_rw     (ua_rw),
    .ua_a      (ua_a),
    .ua_b      (ua_b),
    .ua_dout   (ua_dout),
    .ua_c      (ua_c)
  );

  // Adder model: accumulate ones while reading, replay that many ones once writing starts.
  logic [5:0] m_cnt = '0;
  always @(posedge clk) begin
    if (!ua_rst_n) begin
      m_cnt   <= '0;
      ua_dout <= 1'b0;
      ua_c    <= 1'b0;
    end else if (ua_en && !ua_rw) begin
      m_cnt   <= m_cnt + 6'(ua_a) + 6'(ua_b);
      ua_dout <= 1'b0;
      if ((m_cnt + 6'(ua_a) + 6'(ua_b)) > 6'd15)
        ua_c <= 1'b1;
    end else if (ua_en && ua_rw && (m_cnt != 0)) begin
      ua_dout <= 1'b1;
      m_cnt   <= m_cnt - 6'd1;
    end else begin
      ua_dout <= 1'b0;
    end
  end

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] sum;
    logic       c;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm, input logic [1:0] exp);
    int n = 0;
    while (req_ready == 2'b00 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(nm, {30'd0, req_ready}, {30'd0, exp});
  endtask

  task automatic wait_rsp(input string nm, input logic exp_id, input logic [4:0] exp_sum);
    int n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({nm, " valid"}, {31'd0, rsp_valid}, 32'd1);
    check({nm, " id"}, {31'd0, rsp_id}, {31'd0, exp_id});
    check({nm, " sum"}, {27'd0, rsp_sum}, {27'd0, exp_sum});
  endtask

  task automatic do_job(input int id, input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] es, input logic ec);
    int n = 0, lat = 0, k = 0, ea = 0, eb = 0, ep = 0;
    req_a[id*4 +: 4] = a;
    req_b[id*4 +: 4] = b;
    req_valid[id]    = 1'b1;
    while (req_ready == 2'b00 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("vec grant", {30'd0, req_ready}, 32'd1 << id);
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) req_valid[id] = 1'b0;
      if (req_ready != 2'b00) ep++;
      if (ua_en && !ua_rw) begin
        if (ua_a != (k < a)) ea++;
        if (ua_b != (k < b)) eb++;
        k++;
      end
    end
    check("vec latency", lat, 48);
    check("vec load cycles", k, 15);
    check("vec ua_a stream errs", ea, 0);
    check("vec ua_b stream errs", eb, 0);
    check("vec ready pulse extra", ep, 0);
    check("vec rsp_id", {31'd0, rsp_id}, id);
    check("vec rsp_sum", {27'd0, rsp_sum}, {27'd0, es});
    check("vec rsp_c", {31'd0, rsp_c}, {31'd0, ec});
    @(negedge clk);
    check("vec rsp_valid drop", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t vecs[6];
    int   err;
    vecs[0] = '{0, 4'd3,  4'd5,  5'd8,  1'b0};
    vecs[1] = '{1, 4'd15, 4'd15, 5'd30, 1'b1};
    vecs[2] = '{0, 4'd0,  4'd0,  5'd0,  1'b0};
    vecs[3] = '{1, 4'd7,  4'd9,  5'd16, 1'b1};
    vecs[4] = '{0, 4'd15, 4'd0,  5'd15, 1'b0};
    vecs[5] = '{1, 4'd8,  4'd0,  5'd8,  1'b0};

    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset outputs", {17'd0, req_ready, rsp_valid, rsp_id, rsp_sum, rsp_c,
                            ua_rst_n, ua_en, ua_rw, ua_a, ua_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle ua_rst_n", {31'd0, ua_rst_n}, 32'd1);
    check("idle ua_en", {31'd0, ua_en}, 32'd0);

    for (int i = 0; i < 6; i++)
      do_job(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].c);

    // Both requesters valid continuously: strict alternation, single-cycle accepts.
    req_a     = {4'd4, 4'd2};
    req_b     = {4'd4, 4'd3};
    req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_ready("rr grant", (j % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
      check("rr ready pulse", {30'd0, req_ready}, 32'd0);
      wait_rsp("rr rsp", j[0], (j % 2 == 0) ? 5'd5 : 5'd8);
    end
    @(negedge clk);

    // Stall in RESP with another request pending.
    req_a     = {4'd4, 4'd6};
    req_b     = {4'd4, 4'd1};
    rsp_ready = 1'b0;
    wait_ready("stall grant", 2'b01);
    wait_rsp("stall rsp", 1'b0, 5'd7);
    err = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_sum != 5'd7 || rsp_id != 1'b0 || req_ready != 2'b00) err++;
    end
    check("stall hold errs", err, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("stall release", {31'd0, rsp_valid}, 32'd0);
    wait_ready("pending grant", 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp("pending rsp", 1'b1, 5'd8);
    @(negedge clk);

    // Reset during LOAD aborts the job; pointer returns to requester 0.
    req_a     = {4'd1, 4'd9};
    req_b     = {4'd1, 4'd2};
    req_valid = 2'b01;
    wait_ready("abort grant", 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    err = 0;
    while (!(ua_en && !ua_rw) && err < 20) begin
      @(negedge clk);
      err++;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midjob reset outputs", {17'd0, req_ready, rsp_valid, rsp_id, rsp_sum, rsp_c,
                                   ua_rst_n, ua_en, ua_rw, ua_a, ua_b}, 32'd0);
    rst_n = 1'b1;
    err = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (rsp_valid || req_ready != 2'b00) err++;
    end
    check("aborted job silent", err, 0);
    req_valid = 2'b11;
    wait_ready("represent grant", 2'b01);
    @(negedge clk);
    req_valid = 2'b10;
    wait_rsp("represent rsp", 1'b0, 5'd11);
    wait_ready("after reset grant1", 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp("after reset rsp1", 1'b1, 5'd2);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
